// File: rtl/display_scan_blank_pkg.sv
// rtl/display_scan_blank_pkg.sv - segment encodings and anode constants for the digit scanner
package display_scan_blank_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for the full hex set
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Wide enough for up to 16 digits; users slice to NUM_DIGITS
  localparam logic [15:0] ANODE_ALL_OFF = 16'hFFFF;

  function automatic logic [15:0] anode_select(input logic [3:0] idx);
    return ~(16'h0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_blank_if.sv
// rtl/display_scan_blank_if.sv - digit/blink inputs and display drive outputs of the scanner
interface display_scan_blank_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable_wire;
  logic [4*NUM_DIGITS-1:0]   digits_wire;
  logic [NUM_DIGITS-1:0]     dp_wire;
  logic                      blink_wire;
  logic [NUM_DIGITS-1:0]     blink_mask_wire;
  logic [NUM_DIGITS-1:0]     anode_n;
  logic [6:0]                seg_n;
  logic                      dp_n;

  modport master (
    output enable_wire, digits_wire, dp_wire, blink_wire, blink_mask_wire,
    input  anode_n, seg_n, dp_n
  );

  modport slave (
    input  enable_wire, digits_wire, dp_wire, blink_wire, blink_mask_wire,
    output anode_n, seg_n, dp_n
  );
endinterface

// File: rtl/display_scan_blank_seg7_decode.sv
// rtl/display_scan_blank_seg7_decode.sv - combinational hex to active-low seven-segment decoder
module seg7_decode
  import display_scan_blank_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = SEG_BLANK;
    case (value)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/display_scan_blank.sv
// rtl/display_scan_blank.sv - multiplexed common-anode digit scanner with blink blanking
module display_scan_blank
  import display_scan_blank_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n_wire,
  display_scan_blank_if.slave  bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ALL_OFF[NUM_DIGITS-1:0];

  logic [CNT_W-1:0]      div_cnt, div_cnt_nxt;
  logic [IDX_W-1:0]      digit_idx, digit_idx_nxt;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic [15:0]           anode_wide;
  logic                  blank;
  logic [NUM_DIGITS-1:0] anode_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  always_comb begin
    div_cnt_nxt   = div_cnt + CNT_W'(1);
    digit_idx_nxt = digit_idx;
    if (div_cnt == CNT_W'(SCAN_DIV - 1)) begin
      div_cnt_nxt   = '0;
      digit_idx_nxt = (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end
  end

  // Single decoder placed after the digit mux
  assign nibble = bus.digits_wire[4*int'(digit_idx) +: 4];

  seg7_decode u_seg7_decode (
    .value (nibble),
    .seg_n (seg_dec)
  );

  always_comb begin
    blank      = bus.blink_wire & bus.blink_mask_wire[digit_idx];
    anode_wide = anode_select(4'(digit_idx));
    anode_nxt  = ANODE_OFF;
    seg_nxt    = SEG_BLANK;
    dp_nxt     = 1'b1;
    if (!blank) begin
      anode_nxt = anode_wide[NUM_DIGITS-1:0];
      seg_nxt   = seg_dec;
      dp_nxt    = ~bus.dp_wire[digit_idx];
    end
  end

  // Disable behaves like a synchronous reset so re-enable starts a full slot at digit 0
  always_ff @(posedge clk or negedge reset_n_wire) begin
    if (!reset_n_wire) begin
      div_cnt     <= '0;
      digit_idx   <= '0;
      bus.anode_n <= ANODE_OFF;
      bus.seg_n   <= SEG_BLANK;
      bus.dp_n    <= 1'b1;
    end else if (!bus.enable_wire) begin
      div_cnt     <= '0;
      digit_idx   <= '0;
      bus.anode_n <= ANODE_OFF;
      bus.seg_n   <= SEG_BLANK;
      bus.dp_n    <= 1'b1;
    end else begin
      div_cnt     <= div_cnt_nxt;
      digit_idx   <= digit_idx_nxt;
      bus.anode_n <= anode_nxt;
      bus.seg_n   <= seg_nxt;
      bus.dp_n    <= dp_nxt;
    end
  end
endmodule

// File: tb/tb_display_scan_blank.sv
// tb/tb_display_scan_blank.sv - directed self-checking bench for display_scan_blank
module tb_display_scan_blank;
  logic clk;
  logic reset_n_wire;
  int   total;
  int   bad;

  display_scan_blank_if #(.NUM_DIGITS(4)) bus ();

  display_scan_blank #(.NUM_DIGITS(4), .SCAN_DIV(2)) dut (
    .clk          (clk),
    .reset_n_wire (reset_n_wire),
    .bus          (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_anode"}, 32'(bus.anode_n), 32'hF);
    chk({tag, "_seg"},   32'(bus.seg_n),   32'h7F);
    chk({tag, "_dp"},    32'(bus.dp_n),    32'h1);
  endtask

  logic [3:0] scan_anode [9];
  logic [6:0] scan_seg   [9];
  logic [6:0] hex_seg    [8];
  logic       hex_dp     [8];
  logic [3:0] exp_anode;
  logic [6:0] exp_seg;
  int         idx;
  logic [3:0] a;

  initial begin
    total = 0;
    bad   = 0;
    scan_anode = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b1110};
    scan_seg   = '{7'b0011001, 7'b0011001, 7'b0110000, 7'b0110000,
                   7'b0100100, 7'b0100100, 7'b1111001, 7'b1111001, 7'b0011001};
    hex_seg    = '{7'b1000110, 7'b1000110, 7'b0100001, 7'b0100001,
                   7'b0000110, 7'b0000110, 7'b0001110, 7'b0001110};
    hex_dp     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    reset_n_wire        = 1'b1;
    bus.enable_wire     = 1'b0;
    bus.digits_wire     = 16'h0000;
    bus.dp_wire         = 4'b0000;
    bus.blink_wire      = 1'b0;
    bus.blink_mask_wire = 4'b0000;
    #3 reset_n_wire = 1'b0;
    #1 chk_dark("reset_initial");

    // Scan order with digits 1234
    @(negedge clk);
    bus.enable_wire = 1'b1;
    bus.digits_wire = 16'h1234;
    @(negedge clk);
    reset_n_wire = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step();
      chk($sformatf("scan_anode_e%0d", e + 1), 32'(bus.anode_n), 32'(scan_anode[e]));
      chk($sformatf("scan_seg_e%0d", e + 1),   32'(bus.seg_n),   32'(scan_seg[e]));
      chk($sformatf("scan_dp_e%0d", e + 1),    32'(bus.dp_n),    32'h1);
    end

    // Asynchronous reset mid-slot darkens at once, before any edge
    @(posedge clk);
    #2 reset_n_wire = 1'b0;
    #1 chk_dark("reset_midscan");

    // Blink blanking on digits 0-1 with 8888; blink flips every 500 cycles, landing mid-slot
    @(negedge clk);
    bus.digits_wire     = 16'h8888;
    bus.blink_mask_wire = 4'b0011;
    reset_n_wire        = 1'b1;
    for (int n = 0; n < 1200; n++) begin
      bus.blink_wire = (((n + 1) / 500) % 2) == 1;
      step();
      idx = (n / 2) % 4;
      if (bus.blink_wire && idx < 2) begin
        exp_anode = 4'hF;
        exp_seg   = 7'b1111111;
      end else begin
        exp_anode = ~(4'b0001 << idx);
        exp_seg   = 7'b0000000;
      end
      chk($sformatf("blink_anode_n%0d", n), 32'(bus.anode_n), 32'(exp_anode));
      chk($sformatf("blink_seg_n%0d", n),   32'(bus.seg_n),   32'(exp_seg));
    end

    // Enable drop at edge 4, then re-enable
    bus.blink_wire      = 1'b0;
    bus.blink_mask_wire = 4'b0000;
    bus.enable_wire     = 1'b0;
    step();
    chk_dark("en_off_pre");
    bus.digits_wire = 16'h1234;
    bus.enable_wire = 1'b1;
    step(); chk("en_e1", 32'(bus.anode_n), 32'hE);
    step(); chk("en_e2", 32'(bus.anode_n), 32'hE);
    step(); chk("en_e3", 32'(bus.anode_n), 32'hD);
    bus.enable_wire = 1'b0;
    step(); chk_dark("en_drop_e4");
    step(); chk_dark("en_drop_e5");
    bus.enable_wire = 1'b1;
    step(); chk("reen_e1", 32'(bus.anode_n), 32'hE);
    chk("reen_seg_e1", 32'(bus.seg_n), 32'(7'b0011001));
    step(); chk("reen_e2", 32'(bus.anode_n), 32'hE);
    step(); chk("reen_e3", 32'(bus.anode_n), 32'hD);

    // Hex decode and decimal point on digit 2
    bus.enable_wire = 1'b0;
    step();
    bus.digits_wire = 16'hFEDC;
    bus.dp_wire     = 4'b0100;
    bus.enable_wire = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      chk($sformatf("hex_anode_e%0d", e + 1), 32'(bus.anode_n), 32'(scan_anode[e]));
      chk($sformatf("hex_seg_e%0d", e + 1),   32'(bus.seg_n),   32'(hex_seg[e]));
      chk($sformatf("hex_dp_e%0d", e + 1),    32'(bus.dp_n),    32'(hex_dp[e]));
    end

    // Random stimulus: anode never has more than one bit low
    for (int n = 0; n < 20000; n++) begin
      bus.enable_wire     = ($urandom_range(0, 7) != 0);
      bus.digits_wire     = 16'($urandom());
      bus.dp_wire         = 4'($urandom());
      bus.blink_wire      = 1'($urandom());
      bus.blink_mask_wire = 4'($urandom());
      reset_n_wire        = ($urandom_range(0, 299) != 0);
      step();
      a = bus.anode_n;
      chk($sformatf("rand_onehot_n%0d", n), 32'((4 - $countones(a)) <= 1 && !$isunknown(a)), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
